// File: rtl/dfd_packetizer_arbiter.sv
// Round-robin arbiter sharing one trace packetizer between NUM_SRC packet generators,
// with a drain/flush/wait-empty sequencer guarded by a timeout.
module dfd_packetizer_arbiter #(
  parameter int  NUM_SRC               = 4,
  parameter int  PACKET_WIDTH_IN_BYTES = 10,
  parameter int  FLUSH_TIMEOUT         = 1023,
  localparam int REQ_W                 = $clog2(PACKET_WIDTH_IN_BYTES) + 1,
  localparam int PW                    = PACKET_WIDTH_IN_BYTES
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REQ_W-1:0]  src_req_bytes,
  output logic [NUM_SRC-1:0]        src_grant,
  input  logic [NUM_SRC*PW*8-1:0]   src_data,
  input  logic [NUM_SRC*PW-1:0]     src_data_be,
  output logic [REQ_W-1:0]          pkt_req_bytes,
  input  logic                      pkt_granted,
  output logic [PW*8-1:0]           pkt_data,
  output logic [PW-1:0]             pkt_data_be,
  input  logic                      flush_req,
  output logic                      pkt_flush_mode_enable,
  input  logic                      pkt_flush_mode_exit,
  input  logic                      pkt_empty,
  output logic                      flush_busy,
  output logic                      flush_done,
  output logic                      flush_timeout
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_WAIT_EMPTY = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   winner_q_r;
  logic               data_vld_r;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic               flush_en_r;
  logic               busy_r;
  logic               done_r;
  logic               timeout_r;

  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   rr_next_s;
  logic [REQ_W-1:0]   winner_req_s;
  logic               found_s;
  logic               grant_fire_s;
  logic               tmo_hit_s;
  int                 idx_s;

  // Round-robin search: first source with a nonzero request starting at rr_ptr_r
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx_s = (int'(rr_ptr_r) + i) % NUM_SRC;
      if (!found_s && (src_req_bytes[idx_s*REQ_W +: REQ_W] != '0)) begin
        winner_s = IDX_W'(idx_s);
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Derived arbitration and timeout terms
  always_comb begin
    winner_req_s = src_req_bytes[winner_s*REQ_W +: REQ_W];
    grant_fire_s = (state_r == ST_IDLE) && found_s && pkt_granted;
    tmo_hit_s    = (tmo_cnt_r >= TMO_LAST_C);
    if (int'(winner_s) == NUM_SRC - 1) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = winner_s + IDX_W'(1);
    end
  end

  // Request forwarding and zero-latency grant return, only while arbitrating
  always_comb begin
    src_grant     = '0;
    pkt_req_bytes = '0;
    if ((state_r == ST_IDLE) && found_s) begin
      pkt_req_bytes       = winner_req_s;
      src_grant[winner_s] = pkt_granted;
    end else begin
      pkt_req_bytes = '0;
      src_grant     = '0;
    end
  end

  // Data beat mux: the granted source's data one cycle after its grant
  always_comb begin
    pkt_data    = '0;
    pkt_data_be = '0;
    if (data_vld_r) begin
      pkt_data    = src_data[winner_q_r*(PW*8) +: PW*8];
      pkt_data_be = src_data_be[winner_q_r*PW +: PW];
    end else begin
      pkt_data    = '0;
      pkt_data_be = '0;
    end
  end

  // Arbitration state: pointer advances past the winner on every grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r   <= '0;
      winner_q_r <= '0;
      data_vld_r <= 1'b0;
    end else if (grant_fire_s) begin
      rr_ptr_r   <= rr_next_s;
      winner_q_r <= winner_s;
      data_vld_r <= 1'b1;
    end else begin
      data_vld_r <= 1'b0;
    end
  end

  // Flush sequencer with registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      tmo_cnt_r  <= '0;
      flush_en_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (flush_req) begin
            state_r <= ST_DRAIN;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Hold until the last granted beat has left the mux
          if (!data_vld_r) begin
            state_r    <= ST_FLUSH;
            flush_en_r <= 1'b1;
            tmo_cnt_r  <= '0;
          end else begin
            state_r    <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (pkt_flush_mode_exit) begin
            state_r    <= ST_WAIT_EMPTY;
            flush_en_r <= 1'b0;
            tmo_cnt_r  <= tmo_cnt_r + 10'd1;
          end else if (tmo_hit_s) begin
            state_r    <= ST_IDLE;
            flush_en_r <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b1;
          end else begin
            tmo_cnt_r  <= tmo_cnt_r + 10'd1;
          end
        end
        ST_WAIT_EMPTY: begin
          if (pkt_empty) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else if (tmo_hit_s) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 10'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          flush_en_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_flush_mode_enable = flush_en_r;
  assign flush_busy            = busy_r;
  assign flush_done            = done_r;
  assign flush_timeout         = timeout_r;

endmodule

// File: tb/tb_dfd_packetizer_arbiter.sv
// Directed and randomized bench for dfd_packetizer_arbiter against a cycle-level
// reference model of the arbitration and flush rules.
module tb_dfd_packetizer_arbiter;

  localparam int NS  = 4;
  localparam int PW  = 10;
  localparam int RW  = 5;
  localparam int TMO = 8;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_FLUSH = 2, P_WAIT = 3;

  logic              clock;
  logic              reset_n;
  logic [NS*RW-1:0]  src_req_bytes;
  logic [NS-1:0]     src_grant;
  logic [NS*PW*8-1:0] src_data;
  logic [NS*PW-1:0]  src_data_be;
  logic [RW-1:0]     pkt_req_bytes;
  logic              pkt_granted;
  logic [PW*8-1:0]   pkt_data;
  logic [PW-1:0]     pkt_data_be;
  logic              flush_req;
  logic              pkt_flush_mode_enable;
  logic              pkt_flush_mode_exit;
  logic              pkt_empty;
  logic              flush_busy;
  logic              flush_done;
  logic              flush_timeout;

  dfd_packetizer_arbiter #(
    .NUM_SRC(NS), .PACKET_WIDTH_IN_BYTES(PW), .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .src_req_bytes(src_req_bytes), .src_grant(src_grant),
    .src_data(src_data), .src_data_be(src_data_be),
    .pkt_req_bytes(pkt_req_bytes), .pkt_granted(pkt_granted),
    .pkt_data(pkt_data), .pkt_data_be(pkt_data_be),
    .flush_req(flush_req), .pkt_flush_mode_enable(pkt_flush_mode_enable),
    .pkt_flush_mode_exit(pkt_flush_mode_exit), .pkt_empty(pkt_empty),
    .flush_busy(flush_busy), .flush_done(flush_done), .flush_timeout(flush_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // reference model state
  int  m_rr, m_wq, m_phase, m_spent;
  bit  m_vld, m_done, m_to;
  int  e_win;
  bit  e_fire;
  logic [NS-1:0]   e_gnt;
  logic [RW-1:0]   e_req;
  logic [PW*8-1:0] e_data;
  logic [PW-1:0]   e_be;
  int  done_count;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] req_of(input int idx);
    return src_req_bytes[idx*RW +: RW];
  endfunction

  task automatic set_req(input int i, input logic [RW-1:0] v);
    src_req_bytes[i*RW +: RW] = v;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NS*PW*8/32; w++) src_data[w*32 +: 32] = $urandom;
    src_data_be = 40'({$urandom, $urandom});
  endtask

  task automatic model_reset();
    m_rr = 0; m_wq = 0; m_vld = 0; m_phase = P_IDLE; m_spent = 0;
    m_done = 0; m_to = 0; e_fire = 0; e_win = -1;
  endtask

  task automatic model_comb();
    e_win = -1;
    for (int k = 0; k < NS; k++) begin
      int idx;
      idx = (m_rr + k) % NS;
      if (e_win < 0 && req_of(idx) != 0) e_win = idx;
    end
    e_fire = (m_phase == P_IDLE) && (e_win >= 0) && pkt_granted;
    e_gnt  = e_fire ? NS'(1 << e_win) : '0;
    e_req  = (m_phase == P_IDLE && e_win >= 0) ? req_of(e_win) : '0;
    e_data = m_vld ? src_data[m_wq*PW*8 +: PW*8] : '0;
    e_be   = m_vld ? src_data_be[m_wq*PW +: PW] : '0;
  endtask

  task automatic model_update();
    bit old_vld;
    old_vld = m_vld;
    if (e_fire) begin
      m_rr = (e_win + 1) % NS; m_wq = e_win; m_vld = 1;
    end else begin
      m_vld = 0;
    end
    m_done = 0;
    case (m_phase)
      P_IDLE:  if (flush_req) m_phase = P_DRAIN;
      P_DRAIN: if (!old_vld) begin m_phase = P_FLUSH; m_spent = 0; end
      P_FLUSH: begin
        m_spent++;
        if (pkt_flush_mode_exit) m_phase = P_WAIT;
        else if (m_spent >= TMO) begin m_phase = P_IDLE; m_to = 1; end
      end
      P_WAIT: begin
        m_spent++;
        if (pkt_empty) begin m_phase = P_IDLE; m_done = 1; end
        else if (m_spent >= TMO) begin m_phase = P_IDLE; m_to = 1; end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  // check every output against the model, then advance one clock
  task automatic cycle(input string tag);
    #1;
    model_comb();
    chk({tag, "_grant"},   80'(src_grant),             80'(e_gnt));
    chk({tag, "_req"},     80'(pkt_req_bytes),         80'(e_req));
    chk({tag, "_data"},    80'(pkt_data),              80'(e_data));
    chk({tag, "_be"},      80'(pkt_data_be),           80'(e_be));
    chk({tag, "_enable"},  80'(pkt_flush_mode_enable), 80'(m_phase == P_FLUSH));
    chk({tag, "_busy"},    80'(flush_busy),            80'(m_phase != P_IDLE));
    chk({tag, "_done"},    80'(flush_done),            80'(m_done));
    chk({tag, "_timeout"}, 80'(flush_timeout),         80'(m_to));
    if (flush_done) done_count++;
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic zero_inputs();
    src_req_bytes = '0; src_data = '0; src_data_be = '0; pkt_granted = 1'b0;
    flush_req = 1'b0; pkt_flush_mode_exit = 1'b0; pkt_empty = 1'b0;
  endtask

  initial begin
    logic [NS-1:0] t1_exp [5];
    t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    done_count = 0;
    reset_n = 1'b0;
    zero_inputs();
    model_reset();
    #3;
    chk("rst_grant",   80'(src_grant), 80'd0);
    chk("rst_req",     80'(pkt_req_bytes), 80'd0);
    chk("rst_data",    80'(pkt_data), 80'd0);
    chk("rst_be",      80'(pkt_data_be), 80'd0);
    chk("rst_enable",  80'(pkt_flush_mode_enable), 80'd0);
    chk("rst_busy",    80'(flush_busy), 80'd0);
    chk("rst_done",    80'(flush_done), 80'd0);
    chk("rst_timeout", 80'(flush_timeout), 80'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // all sources request full packets, packetizer always grants
    for (int i = 0; i < NS; i++) set_req(i, 5'd10);
    pkt_granted = 1'b1;
    for (int n = 0; n < 5; n++) begin
      rand_data();
      #1 chk("t1_rr_order", 80'(src_grant), 80'(t1_exp[n]));
      cycle("t1");
    end

    // single request held while the packetizer withholds its grant
    src_req_bytes = '0;
    set_req(2, 5'd6);
    pkt_granted = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rand_data();
      #1 chk("t2_held_req", 80'(pkt_req_bytes), 80'd6);
      cycle("t2");
    end
    pkt_granted = 1'b1;
    rand_data();
    #1 chk("t2_late_grant", 80'(src_grant), 80'(4'b0100));
    cycle("t2g");

    // pointer sits at 3: src3 beats src0, idle sources carry all-ones enables
    src_req_bytes = '0;
    set_req(0, 5'd7);
    set_req(3, 5'd9);
    rand_data();
    src_data_be[1*PW +: PW] = '1;
    src_data_be[2*PW +: PW] = '1;
    #1 chk("t3_first", 80'(src_grant), 80'(4'b1000));
    cycle("t3a");
    set_req(3, 5'd0);
    rand_data();
    src_data_be[1*PW +: PW] = '1;
    src_data_be[2*PW +: PW] = '1;
    #1 chk("t3_second", 80'(src_grant), 80'(4'b0001));
    cycle("t3b");
    src_req_bytes = '0;
    pkt_granted = 1'b0;
    rand_data();
    src_data_be[1*PW +: PW] = '1;
    src_data_be[2*PW +: PW] = '1;
    cycle("t3c");

    // flush requested in the same cycle as a grant
    set_req(1, 5'd4);
    pkt_granted = 1'b1;
    flush_req = 1'b1;
    rand_data();
    #1 chk("t4_grant_with_flush", 80'(src_grant), 80'(4'b0010));
    cycle("t4a");
    flush_req = 1'b0;
    set_req(3, 5'd2);
    rand_data();
    #1 chk("t4_drain_req", 80'(pkt_req_bytes), 80'd0);
    cycle("t4b");
    rand_data();
    cycle("t4c");
    rand_data();
    #1 chk("t4_enable_up", 80'(pkt_flush_mode_enable), 80'd1);
    cycle("t4d");
    flush_req = 1'b1;
    cycle("t4e");
    flush_req = 1'b0;
    src_req_bytes = '0;
    pkt_flush_mode_exit = 1'b1;
    cycle("t4f");
    pkt_flush_mode_exit = 1'b0;
    cycle("t4g");
    pkt_empty = 1'b1;
    cycle("t4h");
    pkt_empty = 1'b0;
    pkt_granted = 1'b0;
    #1 chk("t4_done_pulse", 80'(flush_done), 80'd1);
    cycle("t4i");
    cycle("t4j");
    chk("t4_done_count", 80'(done_count), 80'd1);

    // flush with exit never asserted runs into the timeout
    flush_req = 1'b1;
    cycle("t5a");
    flush_req = 1'b0;
    for (int n = 0; n < 12; n++) cycle("t5");
    chk("t5_timeout_set", 80'(flush_timeout), 80'd1);
    chk("t5_back_idle", 80'(flush_busy), 80'd0);
    set_req(2, 5'd3);
    pkt_granted = 1'b1;
    rand_data();
    #1 chk("t5_arb_resumes", 80'(src_grant), 80'(4'b0100));
    cycle("t5g");

    // asynchronous reset while in the flush state
    src_req_bytes = '0;
    pkt_granted = 1'b0;
    cycle("t6a");
    flush_req = 1'b1;
    cycle("t6b");
    flush_req = 1'b0;
    cycle("t6c");
    cycle("t6d");
    chk("t6_in_flush", 80'(pkt_flush_mode_enable), 80'd1);
    zero_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_enable",  80'(pkt_flush_mode_enable), 80'd0);
    chk("t6_rst_busy",    80'(flush_busy), 80'd0);
    chk("t6_rst_done",    80'(flush_done), 80'd0);
    chk("t6_rst_timeout", 80'(flush_timeout), 80'd0);
    chk("t6_rst_data",    80'(pkt_data), 80'd0);
    chk("t6_rst_grant",   80'(src_grant), 80'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NS; i++) set_req(i, 5'd10);
    pkt_granted = 1'b1;
    rand_data();
    #1 chk("t6_first_grant", 80'(src_grant), 80'(4'b0001));
    cycle("t6e");

    // randomized traffic with occasional flushes; requests hold until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) begin
        if ((e_fire && e_win == i) || req_of(i) == 0)
          set_req(i, ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 10)));
      end
      pkt_granted         = ($urandom_range(0, 3) != 0);
      flush_req           = ($urandom_range(0, 39) == 0);
      pkt_flush_mode_exit = ($urandom_range(0, 2) == 0);
      pkt_empty           = ($urandom_range(0, 2) == 0);
      rand_data();
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
